// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and a word-wide data memory.
// Sub-word stores use read-modify-write; illegal accesses complete with resp_err and never touch memory.
module load_store_unit #(
    parameter int DEPTH  = 256,
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_ERR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [MEM_AW+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         old_q, old_d;
    logic                err_q, err_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;

    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        if (f3[1:0] == 2'b01 && addr[0])
            bad = 1'b1;
        if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            bad = 1'b1;
        if ({2'b00, addr[31:2]} >= 32'(DEPTH))
            bad = 1'b1;
        return bad;
    endfunction

    // Alignment is already guaranteed, so shifting the lane down to bit 0 works for every width.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {4{wdata[7:0]}};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        old_d        = old_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'h0;
        resp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d    = req_funct3;
                    addr_d  = req_addr[MEM_AW+1:0];
                    wdata_d = req_wdata;
                    data_d  = 32'h0;
                    err_d   = req_error(req_we, req_funct3, req_addr);
                    if (err_d)
                        state_d = S_ERR;
                    else if (!req_we)
                        state_d = S_LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                data_d  = load_extend(mem_rdata, f3_q, addr_q[1:0]);
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                old_d   = mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_ERR:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Response registers load on entry to DONE so they are valid exactly during DONE.
        if (state_d == S_DONE) begin
            resp_valid_d = 1'b1;
            resp_data_d  = data_d;
            resp_err_d   = err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            data_q       <= 32'h0;
            old_q        <= 32'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            old_q        <= old_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign mem_wr     = (state_q == S_WRITE);
    assign mem_addr   = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
    assign mem_wdata  = store_merge(old_q, wdata_q, f3_q[1:0], addr_q[1:0]);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized and directed requests against a byte-level reference
// model; expected responses and memory writes are queued and checked by a separate monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    load_store_unit #(.DEPTH(256), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, write on negedge; preload port used before reset release.
    logic [31:0] tb_mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_data = 32'h0;
    assign mem_rdata = tb_mem[mem_addr[7:0]];
    always @(negedge clk) begin
        if (pl_en)
            tb_mem[pl_idx] <= pl_data;
        else if (mem_wr)
            tb_mem[mem_addr[7:0]] <= mem_wdata;
    end

    typedef struct { logic [31:0] data; logic err; int cyc; } resp_t;
    typedef struct { logic [31:0] idx; logic [31:0] word; int cyc; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    logic [31:0] ref_mem [256];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: works byte by byte on the word array, independent of lane/mask logic.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] data,
                         output bit wr, output logic [31:0] wword, output int lat);
        int size; bit sgn; bit bad; int off; logic [31:0] w; longint v;
        size = 1; sgn = 0; bad = 0; off = int'(addr % 4);
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: bad = 1;
        endcase
        if (we && f3 > 3) bad = 1;
        if (addr % size != 0) bad = 1;
        if (addr / 4 >= 256) bad = 1;
        err = bad; data = 32'h0; wr = 0; wword = 32'h0; lat = 2;
        if (!bad && !we) begin
            w = ref_mem[addr / 4];
            v = 0;
            for (int i = 0; i < size; i++)
                v = v + (longint'((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
            if (sgn && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            data = v[31:0];
        end else if (!bad && we) begin
            w = ref_mem[addr / 4];
            for (int i = 0; i < size; i++)
                w[8 * (off + i) +: 8] = wdata[8 * i +: 8];
            ref_mem[addr / 4] = w;
            wr = 1; wword = w;
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ready) begin ok = 1; break; end
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit has_k, input logic [31:0] kexp,
                         output int acc);
        bit ok; logic err; logic [31:0] data; bit wr; logic [31:0] wword; int lat;
        resp_t r; wr_t x;
        wait_ready(ok);
        acc = -1;
        if (!ok) return;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        acc = cyc;
        model(we, f3, addr, wdata, err, data, wr, wword, lat);
        r.data = (has_k && !we) ? kexp : data;
        r.err = err;
        r.cyc = acc + lat;
        rq.push_back(r);
        if (wr) begin
            x.idx = addr / 4;
            x.word = has_k ? kexp : wword;
            x.cyc = acc + lat - 1;
            wq.push_back(x);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 0;
        end
    endtask

    task automatic monitor_loop();
        resp_t r; wr_t x;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (resp_valid) begin
                    if (rq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                    else begin
                        r = rq.pop_front();
                        chk("resp_data", resp_data, r.data);
                        chk("resp_err", 32'(resp_err), 32'(r.err));
                        chk("resp_cycle", cyc, r.cyc);
                    end
                end
                if (mem_wr) begin
                    if (wq.size() == 0) chk("unexpected_mem_wr", 32'd1, 32'd0);
                    else begin
                        x = wq.pop_front();
                        chk("mem_addr", mem_addr, x.idx);
                        chk("mem_wdata", mem_wdata, x.word);
                        chk("mem_wr_cycle", cyc, x.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        int a1, a2, acc;
        bit ok;
        bit we; logic [2:0] f3; logic [31:0] addr; int r;

        for (int i = 0; i < 256; i++)
            ref_mem[i] = (i == 3) ? 32'h8081_F0F1 : $urandom;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            pl_en = 1; pl_idx = 8'(i); pl_data = ref_mem[i];
            @(posedge clk);
        end
        pl_en = 0;
        @(negedge clk);
        reset = 0;
        fork
            monitor_loop();
        join_none

        issue(0, 3'd0, 32'h0D, 32'h0, 1, 32'hFFFF_FFF0, acc);
        issue(0, 3'd4, 32'h0D, 32'h0, 1, 32'h0000_00F0, acc);
        issue(0, 3'd5, 32'h0E, 32'h0, 1, 32'h0000_8081, acc);
        issue(0, 3'd1, 32'h0E, 32'h0, 1, 32'hFFFF_8081, acc);
        issue(0, 3'd2, 32'h0C, 32'h0, 1, 32'h8081_F0F1, acc);
        issue(1, 3'd0, 32'h0E, 32'h1234_5655, 1, 32'h8055_F0F1, acc);
        issue(1, 3'd1, 32'h0D, 32'hAAAA_BBBB, 0, 32'h0, acc);
        issue(0, 3'd2, 32'h400, 32'h0, 0, 32'h0, acc);
        issue(0, 3'd2, 32'h0C, 32'h0, 1, 32'h8055_F0F1, acc);
        issue(0, 3'd2, 32'h3FC, 32'h0, 0, 32'h0, acc);
        issue(1, 3'd0, 32'h3FF, 32'h0000_00A5, 0, 32'h0, acc);
        issue(0, 3'd0, 32'h3FF, 32'h0, 1, 32'hFFFF_FFA5, acc);
        issue(1, 3'd3, 32'h10, 32'h0, 0, 32'h0, acc);
        issue(1, 3'd4, 32'h10, 32'h0, 0, 32'h0, acc);
        idle(2);

        // Reset asserted while an SW sits in WRITE: write must be cancelled.
        wait_ready(ok);
        req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 0;
        chk("abort_wr_before", 32'(mem_wr), 32'd1);
        reset = 1;
        #1;
        chk("abort_wr_falls", 32'(mem_wr), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("ready_after_release", 32'(ready), 32'd1);
        idle(4);

        issue(1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, a1);
        issue(0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, a2);
        chk("b2b_accept_gap", a2 - a1, 32'd3);

        for (int k = 0; k < 200; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 19);
            if (r == 0) addr = $urandom;
            else if (r == 1) addr = 32'h400 + 32'($urandom_range(0, 255));
            else if (r == 2) addr = 32'($urandom_range(1016, 1023));
            else addr = 32'($urandom_range(0, 63));
            issue(we, f3, addr, $urandom, 0, 32'h0, acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        for (int t = 0; t < 20; t++) begin
            if (rq.size() == 0 && wq.size() == 0) break;
            @(negedge clk);
        end
        chk("resp_queue_drained", rq.size(), 32'd0);
        chk("write_queue_drained", wq.size(), 32'd0);
        for (int i = 0; i < 256; i++)
            chk($sformatf("mem_word_%0d", i), tb_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
